// File: rtl/counter_chk_pkg.sv
// Shared types and constants for the counter sequence checker:
// FSM state encoding, violation codes and default parameter values.
package counter_chk_pkg;

    // Checker FSM states; the encoding is visible on the phase output.
    typedef enum logic [1:0] {
        S_WAIT = 2'd0,
        S_INC  = 2'd1,
        S_DEC  = 2'd2,
        S_ERR  = 2'd3
    } state_e;

    // Violation codes reported on err_code.
    localparam logic [2:0] E_NONE     = 3'd0;
    localparam logic [2:0] E_INC_STEP = 3'd1;
    localparam logic [2:0] E_LOAD     = 3'd2;
    localparam logic [2:0] E_DEC_STEP = 3'd3;
    localparam logic [2:0] E_TIMEOUT  = 3'd4;

    // Default parameter values.
    localparam int unsigned INC_MAX_DEF  = 6;
    localparam int unsigned DEC_LOAD_DEF = 3;
    localparam int unsigned TIMEOUT_DEF  = 64;

    // States in which the observed counters are expected to be moving.
    function automatic logic is_active(input state_e s);
        return (s == S_INC) || (s == S_DEC);
    endfunction

endpackage

// File: rtl/counter_chk_watchdog.sv
// Stall watchdog: counts CE-qualified cycles in which the observed counter
// pair did not change while the checker is in an active phase, and flags
// the cycle in which that count reaches TIMEOUT.
module counter_chk_watchdog
    import counter_chk_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic srst,
    input  logic ce_i,
    input  logic active_i,
    input  logic changed_i,
    output logic timeout_o
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST_IDLE = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] FULL      = CW'(TIMEOUT);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next idle count; the flag fires on the qualifying cycle that makes the
    // count equal TIMEOUT. Phase transitions between active states always
    // coincide with a value change, so clearing on a change also clears on a
    // state change.
    always_comb begin
        cnt_d     = cnt_q;
        timeout_o = 1'b0;
        if (!active_i || changed_i) begin
            cnt_d = '0;
        end else if (ce_i && (cnt_q != FULL)) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_IDLE) begin
                timeout_o = 1'b1;
            end
        end
    end

    // Idle counter register.
    always_ff @(posedge clk) begin
        if (srst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/counter_seq_checker.sv
// Protocol checker for an up/down counter pair. Tracks the expected
// inc 0..INC_MAX then dec DEC_LOAD..0 sequence, counts complete frames and
// latches the first violation. Optional stall watchdog is compiled in with
// the macro COUNTER_SEQ_CHECKER_TIMEOUT_EN.
module counter_seq_checker
    import counter_chk_pkg::*;
#(
    parameter int unsigned INC_MAX  = INC_MAX_DEF,
    parameter int unsigned DEC_LOAD = DEC_LOAD_DEF,
    parameter int unsigned TIMEOUT  = TIMEOUT_DEF
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CE,
    input  logic [7:0]  inc,
    input  logic [7:0]  dec,
    input  logic        err_clr,
    output logic        seq_err,
    output logic [2:0]  err_code,
    output logic [15:0] frame_cnt,
    output logic [1:0]  phase
);

    localparam logic [7:0] INC_MAX_V  = 8'(INC_MAX);
    localparam logic [7:0] DEC_LOAD_V = 8'(DEC_LOAD);

    logic [7:0]  inc_q;
    logic [7:0]  dec_q;
    state_e      state_q;
    state_e      state_d;
    logic        armed_q;
    logic        armed_d;
    logic        seq_err_q;
    logic        seq_err_d;
    logic [2:0]  err_code_q;
    logic [2:0]  err_code_d;
    logic [15:0] frame_q;
    logic [15:0] frame_d;
    logic [2:0]  fault;

    logic hold;
    logic at_max;
    logic up_ok;
    logic dec_ok;
    logic wd_timeout;

    // Per-cycle judgement of the new pair against last cycle's pair.
    assign hold   = (inc == inc_q) && (dec == dec_q);
    assign at_max = (inc_q == INC_MAX_V);
    assign up_ok  = (inc_q < INC_MAX_V) && (inc == inc_q + 8'd1) && (dec == 8'd0);
    assign dec_ok = (inc == inc_q) && (dec_q != 8'd0) && (dec == dec_q - 8'd1);

`ifdef COUNTER_SEQ_CHECKER_TIMEOUT_EN
    counter_chk_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk       (CLK),
        .srst      (RST),
        .ce_i      (CE),
        .active_i  (is_active(state_q)),
        .changed_i (!hold),
        .timeout_o (wd_timeout)
    );
`else
    // No watchdog: CE and TIMEOUT have no effect in this build.
    logic unused_cfg;
    assign unused_cfg = CE ^ (TIMEOUT == 0);
    assign wd_timeout = 1'b0;
`endif

    // Next-state, frame counting and error latching; err_clr beats any
    // violation detected in the same cycle.
    always_comb begin
        state_d    = state_q;
        armed_d    = 1'b0;
        seq_err_d  = seq_err_q;
        err_code_d = err_code_q;
        frame_d    = frame_q;
        fault      = E_NONE;
        if (err_clr) begin
            state_d    = S_WAIT;
            seq_err_d  = 1'b0;
            err_code_d = E_NONE;
        end else begin
            case (state_q)
                S_WAIT: begin
                    if ((inc == 8'd0) && (dec == 8'd0)) begin
                        state_d = S_INC;
                    end
                end
                S_INC: begin
                    if (hold) begin
                        if (wd_timeout) fault = E_TIMEOUT;
                    end else if (at_max && (inc == inc_q) && (dec != 8'd0)) begin
                        if (dec == DEC_LOAD_V) state_d = S_DEC;
                        else                   fault   = E_LOAD;
                    end else if (!up_ok) begin
                        fault = E_INC_STEP;
                    end
                end
                S_DEC: begin
                    if (armed_q && (inc == 8'd0) && (dec == 8'd0)) begin
                        frame_d = frame_q + 16'd1;
                        state_d = S_INC;
                    end else if (hold) begin
                        armed_d = armed_q;
                        if (wd_timeout) fault = E_TIMEOUT;
                    end else if (dec_ok) begin
                        armed_d = (dec == 8'd0);
                    end else begin
                        fault = E_DEC_STEP;
                    end
                end
                default: begin
                end
            endcase
            if (fault != E_NONE) begin
                state_d   = S_ERR;
                armed_d   = 1'b0;
                seq_err_d = 1'b1;
                if (!seq_err_q) err_code_d = fault;
            end
        end
    end

    // State, sample and status registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            inc_q      <= 8'd0;
            dec_q      <= 8'd0;
            state_q    <= S_WAIT;
            armed_q    <= 1'b0;
            seq_err_q  <= 1'b0;
            err_code_q <= E_NONE;
            frame_q    <= 16'd0;
        end else begin
            inc_q      <= inc;
            dec_q      <= dec;
            state_q    <= state_d;
            armed_q    <= armed_d;
            seq_err_q  <= seq_err_d;
            err_code_q <= err_code_d;
            frame_q    <= frame_d;
        end
    end

    assign seq_err   = seq_err_q;
    assign err_code  = err_code_q;
    assign frame_cnt = frame_q;
    assign phase     = state_q;

endmodule

// File: doc/counter_seq_checker.md
COUNTER_SEQ_CHECKER -- requirements
Module: counter_seq_checker

Interface
REQ-001 Parameter INC_MAX, default 6, terminal value of the up-count phase.
REQ-002 Parameter DEC_LOAD, default 3, value loaded at the start of the down-count phase.
REQ-003 Parameter TIMEOUT, default 64, maximum number of cycles with no count change while in S_INC or S_DEC.
REQ-004 Port CLK  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 Port RST  input  1  reset, synchronous to CLK, active-high.
REQ-006 Port CE  input  1  clock enable of the observed counter pair; used only by the watchdog.
REQ-007 Port inc  input  8  observed up-counter value.
REQ-008 Port dec  input  8  observed down-counter value.
REQ-009 Port err_clr  input  1  single-cycle request to clear the sticky error and return to S_WAIT.
REQ-010 Port seq_err  output  1  sticky protocol-violation flag.
REQ-011 Port err_code  output  3  code of the first violation since the last clear.
REQ-012 Port frame_cnt  output  16  number of complete inc/dec sequences.
REQ-013 Port phase  output  2  current FSM state encoding.

Function
REQ-014 The block SHALL register inc and dec as inc_q and dec_q each cycle, and SHALL judge every cycle by comparing the pair (inc, dec) against (inc_q, dec_q).
REQ-015 The FSM SHALL have the states S_WAIT=0, S_INC=1, S_DEC=2 and S_ERR=3, and phase SHALL equal the state encoding.
REQ-016 In S_WAIT, when inc==0 and dec==0, the FSM SHALL go to S_INC on the next cycle; any other value SHALL hold S_WAIT without flagging an error.
REQ-017 In S_INC, a hold or inc==inc_q+1 with inc_q<INC_MAX and dec==0 SHALL be legal; any other change SHALL raise error E_INC_STEP=1.
REQ-018 In S_INC with inc_q==INC_MAX, a change of dec to DEC_LOAD with inc unchanged SHALL move the FSM to S_DEC; a change of dec to any other nonzero value SHALL raise E_LOAD=2.
REQ-019 In S_DEC, a hold or dec==dec_q-1 with inc unchanged SHALL be legal, and dec reaching 0 SHALL arm a restart.
REQ-020 In S_DEC, a dec increase, a step greater than 1, or an inc change before the restart is armed SHALL raise E_DEC_STEP=3.
REQ-021 In S_DEC with the restart armed, inc==0 and dec==0 SHALL increment frame_cnt by 1 (wrapping 0xFFFF to 0) and SHALL return the FSM to S_INC in the same cycle.
REQ-022 On any error, seq_err SHALL be set and err_code SHALL latch on the next edge, and the FSM SHALL enter S_ERR.
REQ-023 While seq_err is set, later errors SHALL NOT overwrite err_code.
REQ-024 In S_ERR, only err_clr SHALL exit; it SHALL clear seq_err and err_code and SHALL move the FSM to S_WAIT, and frame_cnt SHALL be kept.
REQ-025 If err_clr and a new violation occur in the same cycle, err_clr SHALL take priority.

Reset
REQ-026 While RST is high at an edge, the state SHALL become S_WAIT, with seq_err=0, err_code=0, frame_cnt=0, inc_q=0, dec_q=0, the restart disarmed and the watchdog at 0.
REQ-027 RST SHALL take priority over err_clr and over all FSM transitions.
REQ-028 Asserting RST mid-sequence SHALL NOT raise any error.

Configuration
REQ-029 The macro COUNTER_SEQ_CHECKER_TIMEOUT_EN, when defined, SHALL compile in a watchdog that counts CE-qualified cycles without a change of inc or dec while in S_INC or S_DEC.
REQ-030 With the watchdog compiled in, the count reaching TIMEOUT SHALL raise E_TIMEOUT=4, and the count SHALL reset on any value change or state change.
REQ-031 When COUNTER_SEQ_CHECKER_TIMEOUT_EN is undefined, the watchdog SHALL be absent, CE SHALL be unused, and code 4 SHALL never be produced.

Structure
REQ-032 The package counter_chk_pkg SHALL hold the state enum, the err_code constants (E_NONE=0 through E_TIMEOUT=4) and the default parameter constants.
REQ-033 The watchdog SHALL be a sub-module named counter_chk_watchdog, instantiated only under COUNTER_SEQ_CHECKER_TIMEOUT_EN.

Verification
REQ-034 Scenario: reset, then drive the legal sequence inc 0 through 6 with dec 0, then dec 3,2,1,0, then inc=0 and dec=0, twice -> frame_cnt=2, seq_err=0, phase returns to 1.
REQ-035 Scenario: inc jumps 2 to 4 -> seq_err=1 and err_code=1 one cycle later, phase=3.
REQ-036 Scenario: at inc=6, dec loads 5 -> err_code=2; then err_clr pulses -> seq_err=0, phase=0, frame_cnt unchanged.
REQ-037 Scenario: dec steps 3 to 1 -> err_code=3; a following inc glitch leaves err_code at 3.
REQ-038 Scenario: RST is asserted with the FSM in S_DEC (dec=2) -> all outputs at reset values and no error flagged.
REQ-039 Scenario (with COUNTER_SEQ_CHECKER_TIMEOUT_EN defined, TIMEOUT=8): inc is frozen at 3 for 8 CE pulses -> err_code=4; the same stimulus with the macro undefined -> seq_err stays 0.
